boot_rom_loader: RTL and testbench
==================================

Name: boot_rom_loader

Overview:
- Read-side initiator for the 548x32 boot ROM (registered-address, CSN-gated read port).
- On start, copies every ROM word, in order, into the core's instruction/data memory over a req/gnt write port.
- Then asserts fetch enable, which releases the core to execute from DEST_BASE.
- Sits between the ROM macro, the memory crossbar write port and the SoC control logic.

Parameters:
- ROM_WORDS, 548, number of 32-bit words to copy; legal range 1..2**ROM_AW.
- ROM_AW, 10, ROM address width.
- DEST_BASE, 32'h0000_0000, byte address of the first destination word; word-aligned.

Ports:
- CLK  in  1  clock
- RSTN  in  1  asynchronous active-low reset
- start_i  in  1  single-cycle start request
- rom_csn_o  out  1  ROM chip select, active low
- rom_a_o  out  ROM_AW  ROM word address
- rom_q_i  in  32  ROM read data
- mem_req_o  out  1  write request
- mem_gnt_i  in  1  write grant
- mem_we_o  out  1  write enable; constant 1 whenever mem_req_o=1
- mem_be_o  out  4  byte enables; 4'hF whenever mem_req_o=1
- mem_addr_o  out  32  byte address
- mem_wdata_o  out  32  write data
- busy_o  out  1  copy in progress
- done_o  out  1  copy complete; sticky
- fetch_en_o  out  1  core fetch enable; equals done_o

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RSTN.
- Reset values: state=IDLE, idx=0, rom_csn_o=1, rom_a_o=0, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, fetch_en_o=0.
- ROM read timing: the ROM latches rom_a_o at the CLK edge where rom_csn_o=0. rom_q_i is valid from the following cycle and stays stable while rom_csn_o=1.
- FSM states:
  - IDLE: if start_i=1, go to FETCH and set idx=0.
  - FETCH: rom_csn_o=0, rom_a_o=idx. Go to LATCH. Lasts exactly one cycle.
  - LATCH: rom_csn_o=1. Register mem_wdata_o<=rom_q_i and mem_addr_o<=DEST_BASE+(idx<<2). Go to WRITE.
  - WRITE: mem_req_o=1, with addr/wdata/we/be held stable. On the edge where mem_gnt_i=1, drop req:
    - if idx==ROM_WORDS-1, go to DONE;
    - else idx<=idx+1 and go to FETCH.
  - DONE: done_o=fetch_en_o=1, busy_o=0. start_i=1 clears done_o/fetch_en_o and restarts at FETCH with idx=0.
- busy_o=1 in FETCH, LATCH and WRITE.
- Throughput: 3 cycles per word with an immediate grant. Total = 3*ROM_WORDS cycles from start to done_o. done_o rises the cycle after the last grant edge.
- Handshake:
  - mem_req_o never drops before a grant.
  - mem_gnt_i while mem_req_o=0 is ignored.
  - Grant stalls of any length hold all outputs stable; rom_csn_o stays 1 during a stall.
- start_i in FETCH, LATCH or WRITE is ignored.
- Address arithmetic: modulo 2**32, no overflow check. idx is ROM_AW bits wide and never wraps, because the terminal compare precedes the increment.
- Reset mid-copy: immediate return to reset values. mem_req_o drops asynchronously; the partial copy is abandoned and restart begins at word 0.
- Simultaneous start_i and reset release: start_i is not sampled until the first edge with RSTN high.

Optional Feature:
- Macro: BOOT_ROM_LOADER_CHECKSUM_EN.
- When defined:
  - Extra port checksum_o (out, 32): running sum modulo 2**32 of every word granted in the current copy.
  - checksum_o clears to 0 on reset and on each accepted start, and updates on each grant edge.
  - Extra port checksum_err_o (out, 1): valid while done_o=1, asserted when the final sum != 0. The image carries a compensating last word.
  - fetch_en_o = done_o & ~checksum_err_o.
- When not defined: neither port exists and fetch_en_o = done_o.

Decomposition:
- Shared package boot_loader_pkg holds:
  - state enum (IDLE, FETCH, LATCH, WRITE, DONE);
  - BOOT_ROM_WORDS=548, BOOT_ROM_AW=10, DEST_BASE default.
- No sub-module. The checksum accumulator stays inline, guarded by the macro.

Test Plan:
- Reset, then start pulse with mem_gnt_i tied 1, ROM model holding the production image:
  - 548 writes at 0x000..0x88C, data equal to the ROM words;
  - done_o and fetch_en_o rise at cycle 1644 after start.
- Random gnt stalls of 0-7 cycles:
  - mem_req/addr/wdata stay stable during each stall;
  - rom_csn_o stays 1 during each stall;
  - write order and data unchanged.
- start_i pulsed during WRITE of word 10: ignored; the copy continues to word 547; exactly 548 writes total.
- RSTN low at word 200 while mem_req_o=1:
  - req drops immediately and all outputs return to reset values;
  - the next start rewrites from word 0, address DEST_BASE.
- ROM_WORDS=1, DEST_BASE=32'hFFFF_FFFC: one write at 0xFFFF_FFFC; done_o after 3 cycles; a second start in DONE repeats the write.
- With BOOT_ROM_LOADER_CHECKSUM_EN:
  - image summing to 0: checksum_o=0, checksum_err_o=0, fetch_en_o=1;
  - same image with one word incremented by 1: checksum_o=1, checksum_err_o=1, fetch_en_o=0.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the boot ROM loader: FSM state encoding,
// default geometry and the destination address helper.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int          BOOT_ROM_WORDS = 548;
  localparam int          BOOT_ROM_AW    = 10;
  localparam logic [31:0] BOOT_DEST_BASE = 32'h0000_0000;

  // Byte address of destination word idx; wraps modulo 2**32 by construction.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/boot_rom_loader.sv
// Copies the boot ROM image word by word into core memory, then releases fetch.
// Optional running checksum gating fetch enable: BOOT_ROM_LOADER_CHECKSUM_EN.
module boot_rom_loader
  import boot_loader_pkg::*;
#(
  parameter int          ROM_WORDS = BOOT_ROM_WORDS,
  parameter int          ROM_AW    = BOOT_ROM_AW,
  parameter logic [31:0] DEST_BASE = BOOT_DEST_BASE
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              start_i,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_a_o,
  input  logic [31:0]       rom_q_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fetch_en_o
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o,
  output logic              checksum_err_o
`endif
);

  localparam logic [ROM_AW-1:0] LAST_IDX = ROM_AW'(ROM_WORDS - 1);

  state_e            state_r, state_s;
  logic [ROM_AW-1:0] idx_r, idx_s;
  logic [ROM_AW-1:0] rom_a_r, rom_a_s;
  logic              csn_r, csn_s;
  logic              req_r, req_s;
  logic [31:0]       addr_r, addr_s;
  logic [31:0]       wdata_r, wdata_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              fen_r, fen_s;
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_r, sum_s;
  logic              err_r, err_s;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    rom_a_s = rom_a_r;
    csn_s   = 1'b1;
    req_s   = req_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    busy_s  = busy_r;
    done_s  = done_r;
    fen_s   = fen_r;
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
    sum_s   = sum_r;
    err_s   = err_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_s = FETCH;
          idx_s   = '0;
          rom_a_s = '0;
          csn_s   = 1'b0;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          fen_s   = 1'b0;
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
          sum_s   = 32'h0000_0000;
          err_s   = 1'b0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      FETCH: begin
        state_s = LATCH;
      end
      LATCH: begin
        wdata_s = rom_q_i;
        addr_s  = word_addr(DEST_BASE, 32'(idx_r));
        req_s   = 1'b1;
        state_s = WRITE;
      end
      WRITE: begin
        if (mem_gnt_i) begin
          req_s = 1'b0;
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
          sum_s = sum_r + wdata_r;
`endif
          // Terminal compare precedes the increment, so idx never wraps.
          if (idx_r == LAST_IDX) begin
            state_s = DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
            err_s   = (sum_s != 32'h0000_0000);
            fen_s   = (sum_s == 32'h0000_0000);
`else
            fen_s   = 1'b1;
`endif
          end else begin
            idx_s   = idx_r + ROM_AW'(1);
            rom_a_s = idx_r + ROM_AW'(1);
            csn_s   = 1'b0;
            state_s = FETCH;
          end
        end else begin
          req_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns every output to idle immediately.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_r <= IDLE;
      idx_r   <= '0;
      rom_a_r <= '0;
      csn_r   <= 1'b1;
      req_r   <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fen_r   <= 1'b0;
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
      sum_r   <= 32'h0000_0000;
      err_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      rom_a_r <= rom_a_s;
      csn_r   <= csn_s;
      req_r   <= req_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      fen_r   <= fen_s;
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
      sum_r   <= sum_s;
      err_r   <= err_s;
`endif
    end
  end

  assign rom_csn_o   = csn_r;
  assign rom_a_o     = rom_a_r;
  assign mem_req_o   = req_r;
  assign mem_we_o    = req_r;
  assign mem_be_o    = {4{req_r}};
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign fetch_en_o  = fen_r;
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
  assign checksum_o     = sum_r;
  assign checksum_err_o = err_r;
`endif

endmodule

// File: tb/tb_boot_rom_loader.sv
// Scoreboard bench for boot_rom_loader: full copy, grant stalls, ignored start,
// mid-copy reset, single-word wrap-around instance and optional checksum.
module tb_boot_rom_loader;
  import boot_loader_pkg::*;

  localparam int          NW         = BOOT_ROM_WORDS;
  localparam logic [31:0] SMALL_WORD = 32'hCAFE_F00D;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        gnt = 1'b0;
  logic        rom_csn, req, we, busy, done, fen;
  logic [9:0]  rom_a;
  logic [31:0] rom_q, addr, wdata;
  logic [3:0]  be;

  logic        start1 = 1'b0;
  logic        csn1, req1, we1, busy1, done1, fen1;
  logic [9:0]  a1;
  logic [31:0] q1, addr1, wdata1;
  logic [3:0]  be1;
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
  logic [31:0] csum, csum1;
  logic        cerr, cerr1;
`endif

  logic [31:0] image [0:NW-1];
  logic [9:0]  rom_lat = 10'd0;
  logic [9:0]  lat1 = 10'd0;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_wr = 0;
  int   gnt_mode = 0;
  int   wait_cnt = 0;
  bit   mon_en = 1'b0;
  bit   prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  exp_t sb[$];

  boot_rom_loader u_dut (
    .CLK(clk), .RSTN(rstn), .start_i(start),
    .rom_csn_o(rom_csn), .rom_a_o(rom_a), .rom_q_i(rom_q),
    .mem_req_o(req), .mem_gnt_i(gnt), .mem_we_o(we), .mem_be_o(be),
    .mem_addr_o(addr), .mem_wdata_o(wdata),
    .busy_o(busy), .done_o(done), .fetch_en_o(fen)
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
    , .checksum_o(csum), .checksum_err_o(cerr)
`endif
  );

  boot_rom_loader #(.ROM_WORDS(1), .ROM_AW(10), .DEST_BASE(32'hFFFF_FFFC)) u_small (
    .CLK(clk), .RSTN(rstn), .start_i(start1),
    .rom_csn_o(csn1), .rom_a_o(a1), .rom_q_i(q1),
    .mem_req_o(req1), .mem_gnt_i(1'b1), .mem_we_o(we1), .mem_be_o(be1),
    .mem_addr_o(addr1), .mem_wdata_o(wdata1),
    .busy_o(busy1), .done_o(done1), .fetch_en_o(fen1)
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
    , .checksum_o(csum1), .checksum_err_o(cerr1)
`endif
  );

  // ROM models: address registered on a selected edge, data held while deselected.
  always @(posedge clk) begin
    if (!rom_csn) rom_lat <= rom_a;
    if (!csn1) lat1 <= a1;
  end
  assign rom_q = (rom_lat < 10'(NW)) ? image[rom_lat] : 32'hDEAD_BEEF;
  assign q1    = (lat1 == 10'd0) ? SMALL_WORD : 32'hDEAD_BEEF;

  // Grant driver and write monitor: pops the scoreboard on each handshake.
  always @(negedge clk) begin
    exp_t e;
    case (gnt_mode)
      0: gnt = 1'b1;
      1: begin
        if (!req) begin
          gnt = 1'($urandom_range(0, 1));
        end else if (wait_cnt == 0) begin
          gnt = 1'b1;
          wait_cnt = $urandom_range(0, 7);
        end else begin
          gnt = 1'b0;
          wait_cnt--;
        end
      end
      default: gnt = 1'b0;
    endcase
    if (mon_en && rstn) begin
      if (prev_stall) begin
        n_cmp++;
        if (req !== 1'b1 || addr !== prev_addr || wdata !== prev_wdata || rom_csn !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: req=%b csn=%b addr=%h wdata=%h, required req=1 csn=1 addr=%h wdata=%h",
                   req, rom_csn, addr, wdata, prev_addr, prev_wdata);
        end
      end
      if (req && gnt) begin
        n_wr++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL extra_write: addr=%h wdata=%h, required no write", addr, wdata);
        end else begin
          e = sb.pop_front();
          if (addr !== e.a || wdata !== e.d || we !== 1'b1 || be !== 4'hF) begin
            n_fail++;
            $display("FAIL write: addr=%h wdata=%h we=%b be=%h, required addr=%h wdata=%h we=1 be=f",
                     addr, wdata, we, be, e.a, e.d);
          end
        end
      end
      prev_stall = req && !gnt;
      prev_addr  = addr;
      prev_wdata = wdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_image();
    for (int i = 0; i < NW; i++) sb.push_back('{a: BOOT_DEST_BASE + 32'(i * 4), d: image[i]});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [78:0] obs;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {rom_csn, rom_a, req, addr, wdata, busy, done, fen};
    n_cmp++;
    if (obs !== {1'b1, 78'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got %h, required %h", obs, {1'b1, 78'd0});
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_copy_tied();
    int cyc;
    gnt_mode = 0;
    n_wr = 0;
    push_image();
    pulse_start();
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 3 * NW || fen !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL copy_timing: cycles=%0d fetch_en=%b busy=%b, required cycles=%0d fetch_en=1 busy=0",
               cyc, fen, busy, 3 * NW);
    end
    n_cmp++;
    if (n_wr !== NW || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL copy_count: writes=%0d pending=%0d, required writes=%0d pending=0", n_wr, sb.size(), NW);
    end
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
    n_cmp++;
    if (csum !== 32'h0 || cerr !== 1'b0) begin
      n_fail++;
      $display("FAIL checksum_good: sum=%h err=%b, required sum=0 err=0", csum, cerr);
    end
`endif
  endtask

  task automatic test_stalls();
    int cyc;
    gnt_mode = 1;
    n_wr = 0;
    push_image();
    pulse_start();
    wait_done(cyc);
    n_cmp++;
    if (n_wr !== NW || sb.size() !== 0 || done !== 1'b1 || fen !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_copy: writes=%0d pending=%0d done=%b fetch_en=%b, required %0d/0/1/1",
               n_wr, sb.size(), done, fen, NW);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    int k;
    gnt_mode = 0;
    n_wr = 0;
    push_image();
    pulse_start();
    k = 0;
    while (!(n_wr == 10 && req === 1'b1) && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (req !== 1'b1 || n_wr !== 10) begin
      n_fail++;
      $display("FAIL reach_word10: req=%b writes=%0d, required req=1 writes=10", req, n_wr);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || rom_csn !== 1'b0 || rom_a !== 10'd11) begin
      n_fail++;
      $display("FAIL start_in_write: busy=%b csn=%b rom_a=%0d, required busy=1 csn=0 rom_a=11", busy, rom_csn, rom_a);
    end
    wait_done(cyc);
    n_cmp++;
    if (n_wr !== NW || sb.size() !== 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL ignored_start_count: writes=%0d pending=%0d done=%b, required %0d/0/1", n_wr, sb.size(), done, NW);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int k;
    logic [78:0] obs;
    gnt_mode = 0;
    n_wr = 0;
    push_image();
    pulse_start();
    k = 0;
    while (!(n_wr == 200 && req === 1'b1) && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    gnt_mode = 2;
    n_cmp++;
    if (req !== 1'b1 || n_wr !== 200) begin
      n_fail++;
      $display("FAIL reach_word200: req=%b writes=%0d, required req=1 writes=200", req, n_wr);
    end
    #1;
    rstn = 1'b0;
    #1;
    obs = {rom_csn, rom_a, req, addr, wdata, busy, done, fen};
    n_cmp++;
    if (obs !== {1'b1, 78'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got %h, required %h", obs, {1'b1, 78'd0});
    end
    sb.delete();
    gnt_mode = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    n_wr = 0;
    push_image();
    pulse_start();
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 3 * NW || n_wr !== NW || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL recopy: cycles=%0d writes=%0d pending=%0d, required %0d/%0d/0", cyc, n_wr, sb.size(), 3 * NW, NW);
    end
  endtask

  task automatic test_single();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (req1 !== 1'b1 || addr1 !== 32'hFFFF_FFFC || wdata1 !== SMALL_WORD || done1 !== 1'b0) begin
        n_fail++;
        $display("FAIL single_write: req=%b addr=%h wdata=%h done=%b, required 1/fffffffc/%h/0",
                 req1, addr1, wdata1, done1, SMALL_WORD);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (done1 !== 1'b1 || req1 !== 1'b0 || busy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL single_done: done=%b req=%b busy=%b, required done=1 req=0 busy=0", done1, req1, busy1);
      end
    end
  endtask

`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    int cyc;
    image[5] = image[5] + 32'd1;
    gnt_mode = 0;
    n_wr = 0;
    push_image();
    pulse_start();
    wait_done(cyc);
    n_cmp++;
    if (csum !== 32'd1 || cerr !== 1'b1 || fen !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL checksum_bad: sum=%h err=%b fetch_en=%b done=%b, required 1/1/0/1", csum, cerr, fen, done);
    end
    image[5] = image[5] - 32'd1;
  endtask
`endif

  initial begin
    logic [31:0] sum;
    sum = 32'd0;
    for (int i = 0; i < NW - 1; i++) begin
      image[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
      sum = sum + image[i];
    end
    image[NW-1] = 32'd0 - sum;
    mon_en = 1'b1;
    test_reset();
    test_single();
    test_copy_tied();
    test_stalls();
    test_start_ignored();
    test_reset_mid();
`ifdef BOOT_ROM_LOADER_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
